// File: rtl/ahb_master_mux.sv
// rtl/ahb_master_mux.sv - AHB master-to-slave bus mux with data-phase tracking and ERROR IDLE insertion
// Optional per-master performance counters are enabled by defining AHB_MUX_PERF_EN.

`ifndef NUM_MASTERS
`define NUM_MASTERS 4
`endif

module ahb_master_mux #(
    parameter int NUM_MASTERS = `NUM_MASTERS,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MW          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                          Hclk,
    input  logic                          Hresetn,
    input  logic [MW-1:0]                 Hmaster,
    input  logic [NUM_MASTERS*ADDR_W-1:0] Haddr_m,
    input  logic [NUM_MASTERS*2-1:0]      Htrans_m,
    input  logic [NUM_MASTERS-1:0]        Hwrite_m,
    input  logic [NUM_MASTERS*3-1:0]      Hsize_m,
    input  logic [NUM_MASTERS*3-1:0]      Hburst_m,
    input  logic [NUM_MASTERS*DATA_W-1:0] Hwdata_m,
    input  logic                          Hreadyout,
    input  logic                          Hresp_s,
`ifdef AHB_MUX_PERF_EN
    input  logic                          perf_clr,
    output logic [NUM_MASTERS*16-1:0]     xfer_cnt,
    output logic [NUM_MASTERS*8-1:0]      err_cnt,
`endif
    output logic [ADDR_W-1:0]             Haddr,
    output logic [1:0]                    Htrans,
    output logic                          Hwrite,
    output logic [2:0]                    Hsize,
    output logic [2:0]                    Hburst,
    output logic [DATA_W-1:0]             Hwdata,
    output logic                          Hready,
    output logic                          Hresp,
    output logic [MW-1:0]                 Hmaster_data
);

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_ACT  = 2'd1,
        D_ERR1 = 2'd2,
        D_ERR2 = 2'd3
    } dstate_t;

    dstate_t           state_q;
    dstate_t           phase;
    logic              dvalid_q;
    logic [MW-1:0]     hmaster_data_q;
    logic [1:0]        htrans_raw;
    logic              addr_valid;

    // Address-phase mux: an index with no matching master leaves everything zero (IDLE)
    always_comb begin
        Haddr      = '0;
        htrans_raw = 2'b00;
        Hwrite     = 1'b0;
        Hsize      = 3'b000;
        Hburst     = 3'b000;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (Hmaster == MW'(i)) begin
                Haddr      = Haddr_m[i*ADDR_W +: ADDR_W];
                htrans_raw = Htrans_m[i*2 +: 2];
                Hwrite     = Hwrite_m[i];
                Hsize      = Hsize_m[i*3 +: 3];
                Hburst     = Hburst_m[i*3 +: 3];
            end
        end
    end

    // The second ERROR cycle must carry IDLE on the bus whatever the master drives
    assign Htrans     = (state_q == D_ERR2) ? 2'b00 : htrans_raw;
    assign addr_valid = Htrans[1];

    // Write-data mux follows the master that owns the current data phase
    always_comb begin
        Hwdata = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (hmaster_data_q == MW'(i)) begin
                Hwdata = Hwdata_m[i*DATA_W +: DATA_W];
            end
        end
    end

    // IDLE/BUSY data phases finish at once with OKAY; real transfers see the slave
    assign Hready       = dvalid_q ? Hreadyout : 1'b1;
    assign Hresp        = dvalid_q ? Hresp_s : 1'b0;
    assign Hmaster_data = hmaster_data_q;

    // The first ERROR cycle is recognised as it happens, so the registered state
    // can already be D_ERR2 when the slave raises Hready for the second cycle
    always_comb begin
        phase = state_q;
        if (state_q == D_ACT && Hresp_s && !Hreadyout) begin
            phase = D_ERR1;
        end
    end

    // Data-phase FSM plus the master-index / valid pipeline into the data phase
    always_ff @(posedge Hclk) begin
        if (Hresetn) begin
            state_q        <= D_IDLE;
            dvalid_q       <= 1'b0;
            hmaster_data_q <= '0;
        end else begin
            if (Hready) begin
                hmaster_data_q <= Hmaster;
                dvalid_q       <= addr_valid;
            end
            if (state_q == D_ERR2) begin
                dvalid_q <= 1'b0;
            end
            case (phase)
                D_IDLE: if (Hready && addr_valid) state_q <= D_ACT;
                D_ACT:  if (Hreadyout) state_q <= addr_valid ? D_ACT : D_IDLE;
                D_ERR1: state_q <= D_ERR2;
                D_ERR2: state_q <= D_IDLE;
                default: state_q <= D_IDLE;
            endcase
        end
    end

`ifdef AHB_MUX_PERF_EN
    logic [15:0] xfer_q [NUM_MASTERS];
    logic [7:0]  err_q  [NUM_MASTERS];
    logic        xfer_inc;
    logic        err_inc;

    assign xfer_inc = dvalid_q && Hready && !Hresp;
    assign err_inc  = (state_q == D_ERR2);

    // Saturating per-master counters; clear wins over a same-cycle increment
    always_ff @(posedge Hclk) begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (Hresetn || perf_clr) begin
                xfer_q[i] <= '0;
                err_q[i]  <= '0;
            end else if (hmaster_data_q == MW'(i)) begin
                if (xfer_inc && xfer_q[i] != 16'hFFFF) xfer_q[i] <= xfer_q[i] + 16'd1;
                if (err_inc && err_q[i] != 8'hFF)      err_q[i]  <= err_q[i] + 8'd1;
            end
        end
    end

    // Flatten the counter arrays onto the packed output buses
    always_comb begin
        xfer_cnt = '0;
        err_cnt  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            xfer_cnt[i*16 +: 16] = xfer_q[i];
            err_cnt[i*8 +: 8]    = err_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_ahb_master_mux.sv
// tb/tb_ahb_master_mux.sv - scoreboard testbench for ahb_master_mux

module tb_ahb_master_mux;

    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 2;

    localparam int K_READY = 0;
    localparam int K_RESP  = 1;
    localparam int K_TRANS = 2;
    localparam int K_ADDR  = 3;
    localparam int K_WDATA = 4;
    localparam int K_MD    = 5;
    localparam int K_WRITE = 6;
    localparam int K_SIZE  = 7;
    localparam int K_BURST = 8;
    localparam int K_XFER0 = 9;
    localparam int K_ERR0  = 10;

    logic              Hclk;
    logic              Hresetn;
    logic [MW-1:0]     Hmaster;
    logic [NM*AW-1:0]  Haddr_m;
    logic [NM*2-1:0]   Htrans_m;
    logic [NM-1:0]     Hwrite_m;
    logic [NM*3-1:0]   Hsize_m;
    logic [NM*3-1:0]   Hburst_m;
    logic [NM*DW-1:0]  Hwdata_m;
    logic              Hreadyout;
    logic              Hresp_s;
    logic [AW-1:0]     Haddr;
    logic [1:0]        Htrans;
    logic              Hwrite;
    logic [2:0]        Hsize;
    logic [2:0]        Hburst;
    logic [DW-1:0]     Hwdata;
    logic              Hready;
    logic              Hresp;
    logic [MW-1:0]     Hmaster_data;
`ifdef AHB_MUX_PERF_EN
    logic              perf_clr;
    logic [NM*16-1:0]  xfer_cnt;
    logic [NM*8-1:0]   err_cnt;
`endif

    ahb_master_mux #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW)) dut (
        .Hclk(Hclk), .Hresetn(Hresetn), .Hmaster(Hmaster),
        .Haddr_m(Haddr_m), .Htrans_m(Htrans_m), .Hwrite_m(Hwrite_m),
        .Hsize_m(Hsize_m), .Hburst_m(Hburst_m), .Hwdata_m(Hwdata_m),
        .Hreadyout(Hreadyout), .Hresp_s(Hresp_s),
`ifdef AHB_MUX_PERF_EN
        .perf_clr(perf_clr), .xfer_cnt(xfer_cnt), .err_cnt(err_cnt),
`endif
        .Haddr(Haddr), .Htrans(Htrans), .Hwrite(Hwrite), .Hsize(Hsize),
        .Hburst(Hburst), .Hwdata(Hwdata), .Hready(Hready), .Hresp(Hresp),
        .Hmaster_data(Hmaster_data)
    );

    typedef struct {
        string       nm;
        int          k;
        logic [31:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    function automatic logic [31:0] actual(input int k);
        case (k)
            K_READY: return {31'd0, Hready};
            K_RESP:  return {31'd0, Hresp};
            K_TRANS: return {30'd0, Htrans};
            K_ADDR:  return Haddr;
            K_WDATA: return Hwdata;
            K_MD:    return {30'd0, Hmaster_data};
            K_WRITE: return {31'd0, Hwrite};
            K_SIZE:  return {29'd0, Hsize};
            K_BURST: return {29'd0, Hburst};
`ifdef AHB_MUX_PERF_EN
            K_XFER0: return {16'd0, xfer_cnt[15:0]};
            K_ERR0:  return {24'd0, err_cnt[7:0]};
`endif
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: every expectation queued for this cycle is checked mid-cycle
    always @(negedge Hclk) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] a;
            e = sb.pop_front();
            a = actual(e.k);
            n_checks++;
            if (a !== e.v) begin
                n_fails++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", e.nm, a, e.v);
            end
        end
    end

    task automatic exp(input string nm, input int k, input logic [31:0] v);
        sb.push_back('{nm, k, v});
    endtask

    task automatic next_cycle();
        @(posedge Hclk);
        #1;
    endtask

    task automatic set_m(input int m, input logic [1:0] tr, input logic [31:0] a, input logic w);
        Htrans_m[m*2 +: 2]   = tr;
        Haddr_m[m*AW +: AW]  = a;
        Hwrite_m[m]          = w;
    endtask

    initial begin
        Hresetn   = 1'b1;
        Hmaster   = 2'd0;
        Haddr_m   = '0;
        Htrans_m  = '0;
        Hwrite_m  = '0;
        Hsize_m   = '0;
        Hburst_m  = '0;
        Hwdata_m  = '0;
        Hreadyout = 1'b1;
        Hresp_s   = 1'b0;
`ifdef AHB_MUX_PERF_EN
        perf_clr  = 1'b0;
`endif
        next_cycle();
        next_cycle();

        // reset released, bus idle
        Hresetn = 1'b0;
        exp("rst_ready", K_READY, 32'd1);
        exp("rst_resp",  K_RESP,  32'd0);
        exp("rst_md",    K_MD,    32'd0);
        exp("rst_trans", K_TRANS, 32'd0);
`ifdef AHB_MUX_PERF_EN
        exp("rst_xfer0", K_XFER0, 32'd0);
        exp("rst_err0",  K_ERR0,  32'd0);
`endif

        // out-of-range master index selects zeros
        next_cycle();
        Hmaster = 2'd3;
        set_m(0, 2'b10, 32'h40, 1'b1);
        exp("oor_addr",  K_ADDR,  32'd0);
        exp("oor_trans", K_TRANS, 32'd0);
        next_cycle();
        Hmaster   = 2'd0;
        set_m(0, 2'b00, 32'h0, 1'b0);
        Hwdata_m[0 +: DW] = 32'h5555_5555;
        Hreadyout = 1'b0;
        exp("oor_ready_idle", K_READY, 32'd1);
        exp("oor_wdata",      K_WDATA, 32'd0);

        // master 1 NONSEQ write, data next cycle
        next_cycle();
        Hmaster   = 2'd1;
        Hreadyout = 1'b1;
        set_m(1, 2'b10, 32'h100, 1'b1);
        Hsize_m[3 +: 3]  = 3'b010;
        Hburst_m[3 +: 3] = 3'b001;
        exp("w1_addr",  K_ADDR,  32'h100);
        exp("w1_trans", K_TRANS, 32'd2);
        exp("w1_write", K_WRITE, 32'd1);
        exp("w1_size",  K_SIZE,  32'd2);
        exp("w1_burst", K_BURST, 32'd1);
        exp("w1_ready", K_READY, 32'd1);
        next_cycle();
        set_m(1, 2'b00, 32'h104, 1'b0);
        Hwdata_m[DW +: DW] = 32'hA5A5_A5A5;
        exp("w1_md",    K_MD,    32'd1);
        exp("w1_wdata", K_WDATA, 32'hA5A5_A5A5);
        exp("w1_dready", K_READY, 32'd1);
        exp("w1_resp",  K_RESP,  32'd0);

        // wait states while arbiter moves on to master 0
        next_cycle();
        set_m(1, 2'b10, 32'h200, 1'b1);
        exp("ws_a_ready", K_READY, 32'd1);
        next_cycle();
        Hmaster = 2'd0;
        set_m(1, 2'b00, 32'h0, 1'b0);
        set_m(0, 2'b10, 32'h300, 1'b1);
        Hwdata_m[DW +: DW] = 32'h1111_1111;
        Hwdata_m[0 +: DW]  = 32'h2222_2222;
        Hreadyout = 1'b0;
        exp("ws_addr", K_ADDR, 32'h300);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) next_cycle();
            exp("ws_ready_low", K_READY, 32'd0);
            exp("ws_md_hold",   K_MD,    32'd1);
            exp("ws_wdata",     K_WDATA, 32'h1111_1111);
        end
        next_cycle();
        Hreadyout = 1'b1;
        exp("ws_done_ready", K_READY, 32'd1);
        exp("ws_done_md",    K_MD,    32'd1);
        next_cycle();
        set_m(0, 2'b00, 32'h0, 1'b0);
        exp("ws_new_md",    K_MD,    32'd0);
        exp("ws_new_wdata", K_WDATA, 32'h2222_2222);

        // two-cycle ERROR, master keeps driving SEQ
        next_cycle();
        set_m(0, 2'b10, 32'h400, 1'b0);
        exp("er_nonseq", K_TRANS, 32'd2);
        next_cycle();
        set_m(0, 2'b11, 32'h404, 1'b0);
        Hreadyout = 1'b0;
        Hresp_s   = 1'b1;
        exp("er1_ready", K_READY, 32'd0);
        exp("er1_resp",  K_RESP,  32'd1);
        exp("er1_trans", K_TRANS, 32'd3);
        next_cycle();
        Hreadyout = 1'b1;
        exp("er2_ready", K_READY, 32'd1);
        exp("er2_resp",  K_RESP,  32'd1);
        exp("er2_trans", K_TRANS, 32'd0);
        next_cycle();
        Hreadyout = 1'b0;
        exp("er_idle_ready", K_READY, 32'd1);
        exp("er_idle_resp",  K_RESP,  32'd0);
        exp("er_idle_trans", K_TRANS, 32'd3);
        next_cycle();
        set_m(0, 2'b00, 32'h0, 1'b0);
        Hreadyout = 1'b1;
        Hresp_s   = 1'b0;
        exp("er_after_ready", K_READY, 32'd1);

        // reset while a data phase is stalled
        next_cycle();
        Hmaster = 2'd2;
        set_m(2, 2'b10, 32'h500, 1'b1);
        exp("rm_addr", K_ADDR, 32'h500);
        next_cycle();
        set_m(2, 2'b00, 32'h0, 1'b0);
        Hreadyout = 1'b0;
        Hresetn   = 1'b1;
        exp("rm_stall_ready", K_READY, 32'd0);
        exp("rm_stall_md",    K_MD,    32'd2);
        next_cycle();
        Hresetn = 1'b0;
        Hresp_s = 1'b1;
        exp("rm_ready", K_READY, 32'd1);
        exp("rm_resp",  K_RESP,  32'd0);
        exp("rm_md",    K_MD,    32'd0);
        next_cycle();
        Hmaster   = 2'd0;
        Hresp_s   = 1'b0;
        Hreadyout = 1'b1;

`ifdef AHB_MUX_PERF_EN
        // five OKAY transfers from master 0
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            set_m(0, 2'b10, 32'h600 + 32'(i * 4), 1'b1);
        end
        next_cycle();
        set_m(0, 2'b00, 32'h0, 1'b0);
        exp("pf_xfer_4", K_XFER0, 32'd4);
        // one ERROR
        next_cycle();
        set_m(0, 2'b10, 32'h700, 1'b1);
        next_cycle();
        set_m(0, 2'b00, 32'h0, 1'b0);
        Hreadyout = 1'b0;
        Hresp_s   = 1'b1;
        next_cycle();
        Hreadyout = 1'b1;
        next_cycle();
        Hresp_s = 1'b0;
        set_m(0, 2'b10, 32'h800, 1'b1);
        exp("pf_xfer_5", K_XFER0, 32'd5);
        exp("pf_err_1",  K_ERR0,  32'd1);
        // clear together with a completion
        next_cycle();
        set_m(0, 2'b00, 32'h0, 1'b0);
        perf_clr = 1'b1;
        next_cycle();
        perf_clr = 1'b0;
        exp("pf_xfer_clr", K_XFER0, 32'd0);
        exp("pf_err_clr",  K_ERR0,  32'd0);
`endif

        next_cycle();
        @(negedge Hclk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fails++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
